// File: rtl/rf_source_recovery_seq.sv
// ----------------------------------------------------------------------------
// rf_source_recovery_seq
//
// Rebuilds the regfile source table after a branch miss. Instead of restoring
// every entry in one cycle, it clears the table to "architectural" and then
// walks the ROB from the head (oldest) to the mispredicting entry, rewriting
// the source ROB id of every surviving producer. Because the walk runs oldest
// to youngest, the youngest producer of a register is written last and wins.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_branchmiss     single-cycle miss pulse (also restarts a running walk)
//   i_miss_rid       ROB id of the mispredicting entry (sampled with miss)
//   i_rob_head       ROB head at the time of the miss (sampled with miss)
//   i_rob_v          per-entry valid
//   i_rob_rfw        per-entry register-file-write flag
//   i_rob_tgt        per-entry target register
//   o_busy           recovery in progress, dispatch stalls
//   o_clr_all        one-cycle table clear strobe
//   o_wr_en          table write strobe, with o_wr_reg / o_wr_rid
//   o_done           one-cycle completion pulse
//
// Optional feature (macro RFSRC_DUAL_WALK_EN):
//   Adds a second write port (o_wr2_en / o_wr2_reg / o_wr2_rid) carrying entry
//   ptr+1, so the walk handles two entries per cycle. The table must apply
//   port 1 after port 0.
//
// All outputs are registered: each cycle the next state and the entry it will
// present are computed, and the output flops are loaded from that. The ROB is
// frozen while busy is high, so looking up the entry one cycle ahead gives the
// same values as reading it in the WALK cycle itself.
// ----------------------------------------------------------------------------
module rf_source_recovery_seq #(
  parameter int AREGS    = 128,
  parameter int RENTRIES = 16,
  parameter int RBIT     = 6,
  parameter int RIDW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_branchmiss,
  input  logic [RIDW-1:0]     i_miss_rid,
  input  logic [RIDW-1:0]     i_rob_head,
  input  logic [RENTRIES-1:0] i_rob_v,
  input  logic [RENTRIES-1:0] i_rob_rfw,
  input  logic [RBIT:0]       i_rob_tgt [RENTRIES],
  output logic                o_busy,
  output logic                o_clr_all,
  output logic                o_wr_en,
  output logic [RBIT:0]       o_wr_reg,
  output logic [RIDW-1:0]     o_wr_rid,
`ifdef RFSRC_DUAL_WALK_EN
  output logic                o_wr2_en,
  output logic [RBIT:0]       o_wr2_reg,
  output logic [RIDW-1:0]     o_wr2_rid,
`endif
  output logic                o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    WALK = 2'd2,
    DONE = 2'd3
  } state_t;

  // Register 0 and the upper-half alias (index 64) never carry a renamed
  // source, so writes targeting them are dropped.
  localparam logic [RBIT:0] TGT_SKIP = {1'b1, {RBIT{1'b0}}};

  state_t          r_state, w_state_nxt;
  logic [RIDW-1:0] r_ptr, w_ptr_nxt;
  logic [RIDW-1:0] r_stop, w_stop_nxt;
  logic [RIDW-1:0] w_ptr_p1;

  logic            w_busy_nxt, w_clr_nxt, w_done_nxt, w_wr_en_nxt;
  logic [RBIT:0]   w_wr_reg_nxt;
  logic [RIDW-1:0] w_wr_rid_nxt;
`ifdef RFSRC_DUAL_WALK_EN
  logic            w_wr2_en_nxt;
  logic [RBIT:0]   w_wr2_reg_nxt;
  logic [RIDW-1:0] w_wr2_rid_nxt;
  logic [RIDW-1:0] w_ptr_nxt_p1;
`endif

  function automatic logic entry_writes(input logic [RIDW-1:0] idx);
    return i_rob_v[idx] & i_rob_rfw[idx] &
           (i_rob_tgt[idx] != '0) & (i_rob_tgt[idx] != TGT_SKIP) &
           (int'(i_rob_tgt[idx]) < AREGS);
  endfunction

  assign w_ptr_p1 = r_ptr + RIDW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_stop_nxt  = r_stop;

    case (r_state)
      IDLE: w_state_nxt = IDLE;
      CLR:  w_state_nxt = WALK;
      WALK: begin
`ifdef RFSRC_DUAL_WALK_EN
        if ((r_ptr == r_stop) || (w_ptr_p1 == r_stop)) begin
          w_state_nxt = DONE;
        end else begin
          w_ptr_nxt = r_ptr + RIDW'(2);
        end
`else
        if (r_ptr == r_stop) begin
          w_state_nxt = DONE;
        end else begin
          w_ptr_nxt = w_ptr_p1;
        end
`endif
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // A miss in any state (re)starts recovery; abandoned writes are wiped by
    // the fresh clear strobe.
    if (i_branchmiss) begin
      w_state_nxt = CLR;
      w_ptr_nxt   = i_rob_head;
      w_stop_nxt  = i_miss_rid;
    end
  end

  always_comb begin
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_clr_nxt    = (w_state_nxt == CLR);
    w_done_nxt   = (w_state_nxt == DONE);
    w_wr_en_nxt  = (w_state_nxt == WALK) && entry_writes(w_ptr_nxt);
    w_wr_reg_nxt = '0;
    w_wr_rid_nxt = '0;
    if (w_wr_en_nxt) begin
      w_wr_reg_nxt = i_rob_tgt[w_ptr_nxt];
      w_wr_rid_nxt = w_ptr_nxt;
    end
`ifdef RFSRC_DUAL_WALK_EN
    w_ptr_nxt_p1  = w_ptr_nxt + RIDW'(1);
    w_wr2_en_nxt  = (w_state_nxt == WALK) && (w_ptr_nxt != w_stop_nxt) &&
                    entry_writes(w_ptr_nxt_p1);
    w_wr2_reg_nxt = '0;
    w_wr2_rid_nxt = '0;
    if (w_wr2_en_nxt) begin
      w_wr2_reg_nxt = i_rob_tgt[w_ptr_nxt_p1];
      w_wr2_rid_nxt = w_ptr_nxt_p1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_stop    <= '0;
      o_busy    <= 1'b0;
      o_clr_all <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_reg  <= '0;
      o_wr_rid  <= '0;
      o_done    <= 1'b0;
`ifdef RFSRC_DUAL_WALK_EN
      o_wr2_en  <= 1'b0;
      o_wr2_reg <= '0;
      o_wr2_rid <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_stop    <= w_stop_nxt;
      o_busy    <= w_busy_nxt;
      o_clr_all <= w_clr_nxt;
      o_wr_en   <= w_wr_en_nxt;
      o_wr_reg  <= w_wr_reg_nxt;
      o_wr_rid  <= w_wr_rid_nxt;
      o_done    <= w_done_nxt;
`ifdef RFSRC_DUAL_WALK_EN
      o_wr2_en  <= w_wr2_en_nxt;
      o_wr2_reg <= w_wr2_reg_nxt;
      o_wr2_rid <= w_wr2_rid_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rf_source_recovery_seq.sv
// ----------------------------------------------------------------------------
// Bench for rf_source_recovery_seq (default single-port build).
// Directed misses push the expected clear/write/done events, each tagged with
// the cycle it must appear in, onto queues; a monitor on the falling edge pops
// and compares whenever the DUT presents one of those strobes.
// ----------------------------------------------------------------------------
module tb_rf_source_recovery_seq;

  localparam int AREGS    = 128;
  localparam int RENTRIES = 16;
  localparam int RBIT     = 6;
  localparam int RIDW     = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                branchmiss = 1'b0;
  logic [RIDW-1:0]     miss_rid = '0;
  logic [RIDW-1:0]     rob_head = '0;
  logic [RENTRIES-1:0] rob_v = '0;
  logic [RENTRIES-1:0] rob_rfw = '0;
  logic [RBIT:0]       rob_tgt [RENTRIES];
  logic                busy, clr_all, wr_en, done;
  logic [RBIT:0]       wr_reg;
  logic [RIDW-1:0]     wr_rid;
`ifdef RFSRC_DUAL_WALK_EN
  logic                wr2_en;
  logic [RBIT:0]       wr2_reg;
  logic [RIDW-1:0]     wr2_rid;
`endif

  rf_source_recovery_seq #(
    .AREGS(AREGS), .RENTRIES(RENTRIES), .RBIT(RBIT), .RIDW(RIDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_branchmiss(branchmiss),
    .i_miss_rid(miss_rid),
    .i_rob_head(rob_head),
    .i_rob_v(rob_v),
    .i_rob_rfw(rob_rfw),
    .i_rob_tgt(rob_tgt),
    .o_busy(busy),
    .o_clr_all(clr_all),
    .o_wr_en(wr_en),
    .o_wr_reg(wr_reg),
    .o_wr_rid(wr_rid),
`ifdef RFSRC_DUAL_WALK_EN
    .o_wr2_en(wr2_en),
    .o_wr2_reg(wr2_reg),
    .o_wr2_rid(wr2_rid),
`endif
    .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int rg;
    int rid;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_clr[$];
  int  exp_done[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (clr_all === 1'b1) begin
      if (exp_clr.size() == 0) unexpected("clr_all");
      else chk("clr_all cycle", cyc, exp_clr.pop_front());
    end
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) unexpected("wr_en");
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr cycle", cyc, e.cyc);
        chk("wr_reg", int'(wr_reg), e.rg);
        chk("wr_rid", int'(wr_rid), e.rid);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) unexpected("done");
      else chk("done cycle", cyc, exp_done.pop_front());
    end
  end

  // Watchdog: the bench must always end on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issue a miss at the current negedge; returns the cycle t it is sampled in.
  task automatic miss(input int h, input int m, output int t);
    t          = cyc;
    rob_head   = RIDW'(h);
    miss_rid   = RIDW'(m);
    branchmiss = 1'b1;
    @(negedge clk);
    branchmiss = 1'b0;
  endtask

  task automatic push_wr(input int c, input int rg, input int rid);
    wr_t e;
    e.cyc = c; e.rg = rg; e.rid = rid;
    exp_wr.push_back(e);
  endtask

  task automatic rob_clear();
    rob_v   = '0;
    rob_rfw = '0;
    for (int i = 0; i < RENTRIES; i++) rob_tgt[i] = '0;
  endtask

  task automatic rob_ramp();
    rob_v   = '1;
    rob_rfw = '1;
    for (int i = 0; i < RENTRIES; i++) rob_tgt[i] = RBIT'(10 + i);
  endtask

  task automatic drained(input string name);
    chk({name, " writes left"}, exp_wr.size(), 0);
    chk({name, " clears left"}, exp_clr.size(), 0);
    chk({name, " dones left"}, exp_done.size(), 0);
  endtask

  initial begin
    int t, t2;
    rob_clear();
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset clr_all", int'(clr_all), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset done", int'(done), 0);
    chk("reset wr_reg", int'(wr_reg), 0);
    chk("reset wr_rid", int'(wr_rid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single entry, head == miss_rid
    rob_v[3] = 1'b1; rob_rfw[3] = 1'b1; rob_tgt[3] = 7'd5;
    miss(3, 3, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 5, 3);
    exp_done.push_back(t + 3);
    wait_cyc(t + 1);
    chk("t1 busy at t+1", int'(busy), 1);
    wait_cyc(t + 4);
    chk("t1 busy low at t+4", int'(busy), 0);
    repeat (2) @(negedge clk);
    drained("t1");

    // 2: wrap-around walk 14,15,0,1
    rob_ramp();
    miss(14, 1, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 24, 14);
    push_wr(t + 3, 25, 15);
    push_wr(t + 4, 10, 0);
    push_wr(t + 5, 11, 1);
    exp_done.push_back(t + 6);
    wait_cyc(t + 6);
    chk("t2 busy during done", int'(busy), 1);
    wait_cyc(t + 7);
    chk("t2 busy low at t+7", int'(busy), 0);
    repeat (2) @(negedge clk);
    drained("t2");

    // 3: same target register, youngest (rid 4) written last
    rob_clear();
    rob_v[4:2] = 3'b111; rob_rfw[4:2] = 3'b111;
    rob_tgt[2] = 7'd7; rob_tgt[3] = 7'd0; rob_tgt[4] = 7'd7;
    miss(2, 4, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 7, 2);
    push_wr(t + 4, 7, 4);
    exp_done.push_back(t + 5);
    wait_cyc(t + 6);
    chk("t3 busy low at t+6", int'(busy), 0);
    repeat (2) @(negedge clk);
    drained("t3");

    // 4: filtering; only entry 9 writes, walk length still 5
    rob_clear();
    rob_v[5] = 1'b0; rob_rfw[5] = 1'b1; rob_tgt[5] = 7'd20;
    rob_v[6] = 1'b1; rob_rfw[6] = 1'b0; rob_tgt[6] = 7'd21;
    rob_v[7] = 1'b1; rob_rfw[7] = 1'b1; rob_tgt[7] = 7'd0;
    rob_v[8] = 1'b1; rob_rfw[8] = 1'b1; rob_tgt[8] = 7'd64;
    rob_v[9] = 1'b1; rob_rfw[9] = 1'b1; rob_tgt[9] = 7'd30;
    miss(5, 9, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 6, 30, 9);
    exp_done.push_back(t + 7);
    wait_cyc(t + 8);
    chk("t4 busy low at t+8", int'(busy), 0);
    repeat (2) @(negedge clk);
    drained("t4");

    // 5: re-miss during WALK restarts with head 0, miss 2
    rob_ramp();
    miss(4, 12, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 14, 4);
    push_wr(t + 3, 15, 5);
    wait_cyc(t + 3);
    miss(0, 2, t2);
    exp_clr.push_back(t2 + 1);
    push_wr(t2 + 2, 10, 0);
    push_wr(t2 + 3, 11, 1);
    push_wr(t2 + 4, 12, 2);
    exp_done.push_back(t2 + 5);
    wait_cyc(t2 + 6);
    chk("t5 busy low", int'(busy), 0);
    repeat (4) @(negedge clk);
    drained("t5");

    // 6: rst during WALK, then a normal sequence
    miss(0, 7, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 10, 0);
    push_wr(t + 3, 11, 1);
    wait_cyc(t + 3);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 busy after rst", int'(busy), 0);
    chk("t6 wr_en after rst", int'(wr_en), 0);
    chk("t6 done after rst", int'(done), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    drained("t6 abort");
    miss(6, 7, t);
    exp_clr.push_back(t + 1);
    push_wr(t + 2, 16, 6);
    push_wr(t + 3, 17, 7);
    exp_done.push_back(t + 4);
    wait_cyc(t + 5);
    chk("t6 busy low after rerun", int'(busy), 0);
    repeat (2) @(negedge clk);
    drained("t6 rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_source_recovery_seq.md
Name: rf_source_recovery_seq

Overview:
- Multi-cycle sequencer that rebuilds the architectural-register source table after a branch miss.
- Replaces a single-cycle, all-entries restore with an ordered walk of the reorder buffer (ROB), from the ROB head to the mispredicting entry.
- Sits between the ROB and the regfile source table. Drives the table's clear and write strobes, and stalls dispatch while the walk runs.

Parameters:
- AREGS, 128, number of architectural registers.
- RENTRIES, 16, ROB entries; must be a power of two.
- RBIT, 6, MSB of a register index (index width RBIT+1).
- RIDW, 4, ROB id width; log2(RENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- branchmiss  in  1  single-cycle miss pulse
- miss_rid  in  RIDW  ROB id of the mispredicting instruction; sampled with branchmiss
- rob_head  in  RIDW  current ROB head (oldest entry); sampled with branchmiss
- rob_v  in  RENTRIES  per-entry valid
- rob_rfw  in  RENTRIES  per-entry register-file-write flag
- rob_tgt  in  (RBIT+1) x RENTRIES  per-entry target register (array)
- busy  out  1  recovery in progress; dispatch must stall
- clr_all  out  1  one-cycle strobe: table sets every entry to "committed/architectural"
- wr_en  out  1  table write strobe
- wr_reg  out  RBIT+1  register to write
- wr_rid  out  RIDW  ROB id written as the new source
- done  out  1  one-cycle completion pulse

Behaviour:
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- Reset values:
  - busy=0, clr_all=0, wr_en=0, done=0, wr_reg=0, wr_rid=0.
  - FSM=IDLE; ptr=0; stop=0.
- FSM states: IDLE, CLR, WALK, DONE.
- IDLE:
  - If branchmiss=1, latch ptr<=rob_head and stop<=miss_rid, then go to CLR.
  - Otherwise stay in IDLE.
- CLR (one cycle):
  - clr_all=1 and busy=1.
  - Next state is WALK.
- WALK (one entry per cycle):
  - busy=1.
  - wr_en=1 iff rob_v[ptr] & rob_rfw[ptr] & rob_tgt[ptr]!=0 & rob_tgt[ptr]!=64.
  - wr_reg=rob_tgt[ptr] and wr_rid=ptr, both valid when wr_en=1.
  - If ptr==stop, go to DONE. Otherwise ptr<=ptr+1, wrapping modulo RENTRIES.
- DONE (one cycle): busy=1, done=1, then go to IDLE.
- Ordering: the walk runs oldest to youngest. A later write to the same register overrides an earlier one in the table, so the youngest surviving producer wins.
- Entry count: N = ((stop - ptr) mod RENTRIES) + 1, inclusive of the missed entry.
  - head==miss_rid gives N=1.
  - Walk length is at most RENTRIES; the walk never runs past stop.
- Latency for a branchmiss at cycle t:
  - busy and clr_all assert at t+1.
  - Writes occur in cycles t+2 .. t+1+N.
  - done asserts at t+2+N.
  - busy is low at t+3+N.
- Read-sampling rule: rob_v, rob_rfw and rob_tgt are read live in each WALK cycle. The ROB is frozen by the raised busy, so these values are stable.
- branchmiss while busy (CLR/WALK/DONE): restart. Latch the new rob_head and miss_rid, and go to CLR the next cycle. Pending writes are abandoned; the new clr_all wipes them.
- branchmiss in the same cycle as the DONE state: restart takes priority. done still pulses this cycle, and the next state is CLR, not IDLE.
- rst mid-operation: return to IDLE next cycle with all outputs deasserted. No done pulse.

Optional Feature:
- Macro: RFSRC_DUAL_WALK_EN.
- With the macro defined:
  - Adds ports wr2_en, wr2_reg, wr2_rid.
  - WALK processes ptr (port 0) and ptr+1 (port 1) per cycle. Port 1 is suppressed when ptr==stop.
  - ptr advances by 2. WALK exits when ptr==stop or ptr+1==stop.
  - The table must apply port 1 after port 0, so the younger entry wins on the same register.
  - Write-cycle count becomes ceil(N/2).
- Without the macro: single port only, as described above.

Test Plan:
- Reset, then branchmiss with head=3, miss_rid=3, entry 3 valid/rfw/tgt=5 -> clr_all at t+1; wr_en at t+2 with wr_reg=5, wr_rid=3; done at t+3; busy low at t+4.
- Wrap-around: head=14, miss_rid=1, all entries valid/rfw, tgt=10+rid -> writes rid 14,15,0,1 on consecutive cycles with reg 24,25,10,11; done at t+6.
- Same target: head=2, miss_rid=4, entries 2 and 4 both tgt=7, entry 3 tgt=0 -> wr_rid sequence 2, (no write), 4; last write to reg 7 carries rid 4.
- Filtering: entries with rob_v=0, rob_rfw=0, tgt=0 or tgt=64 -> wr_en=0 in those WALK cycles; cycle count unchanged.
- Re-miss: second branchmiss during WALK with head=0, miss_rid=2 -> clr_all the next cycle, then walk of rids 0..2 only; exactly one done pulse.
- rst asserted during WALK -> next cycle busy=0, wr_en=0, no done; a subsequent branchmiss runs a normal sequence.
